// File: rtl/d5m_stream_gen.sv
// D5M sensor-side stream generator: FVAL/LVAL/12-bit pixel timing with
// deterministic test patterns for driving the capture path without a camera.
module d5m_stream_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_BLANK  = 160,
  parameter int unsigned P1_BLANK = 4,
  parameter int unsigned P2_BLANK = 4,
  parameter int unsigned V_BLANK  = 800
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iSTART,
  input  logic        iEND,
  input  logic [1:0]  iMODE,
  input  logic [11:0] iCONST,
  output logic [11:0] oDATA,
  output logic        oFVAL,
  output logic        oLVAL,
  output logic [15:0] oX_Cont,
  output logic [15:0] oY_Cont,
  output logic [15:0] oFrame_Cont,
  output logic        oBUSY
);

  localparam logic [15:0] H_LAST  = 16'(H_ACTIVE - 1);
  localparam logic [15:0] V_LAST  = 16'(V_ACTIVE - 1);
  localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
  localparam logic [15:0] P1_LAST = 16'(P1_BLANK - 1);
  localparam logic [15:0] P2_LAST = 16'(P2_BLANK - 1);
  localparam logic [15:0] VB_LAST = 16'(V_BLANK - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_LINE, S_HBL, S_POST, S_VBL} state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] x_n, y_n;
  logic [15:0] frame_q, frame_n;
  logic [1:0]  mode_q, mode_n;
  logic [11:0] const_q, const_n;
  logic        stop_q, stop_n;
  logic [11:0] data_n;

  assign oFrame_Cont = frame_q;

  // Next-state values feed the output registers so every output changes
  // on the same edge as the state it belongs to.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 16'd1;
    x_n     = oX_Cont;
    y_n     = oY_Cont;
    frame_n = frame_q;
    mode_n  = mode_q;
    const_n = const_q;
    stop_n  = stop_q | (iEND && (state != S_IDLE));
    case (state)
      S_IDLE: begin
        cnt_n  = '0;
        stop_n = 1'b0;
        if (iSTART && !iEND) begin
          state_n = S_PRE;
          mode_n  = iMODE;
          const_n = iCONST;
          x_n     = '0;
          y_n     = '0;
        end
      end
      S_PRE: begin
        if (cnt == P1_LAST) begin
          state_n = S_LINE;
          cnt_n   = '0;
          x_n     = '0;
        end
      end
      S_LINE: begin
        if (cnt == H_LAST) begin
          cnt_n   = '0;
          state_n = (oY_Cont == V_LAST) ? S_POST : S_HBL;
        end else begin
          x_n = oX_Cont + 16'd1;
        end
      end
      S_HBL: begin
        if (cnt == HB_LAST) begin
          state_n = S_LINE;
          cnt_n   = '0;
          x_n     = '0;
          y_n     = oY_Cont + 16'd1;
        end
      end
      S_POST: begin
        if (cnt == P2_LAST) begin
          state_n = S_VBL;
          cnt_n   = '0;
          frame_n = frame_q + 16'd1;
        end
      end
      S_VBL: begin
        if (cnt == VB_LAST) begin
          cnt_n = '0;
          if (stop_n) begin
            state_n = S_IDLE;
            stop_n  = 1'b0;
            x_n     = '0;
            y_n     = '0;
          end else begin
            state_n = S_PRE;
            mode_n  = iMODE;
            const_n = iCONST;
            y_n     = '0;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    data_n = '0;
    if (state_n == S_LINE) begin
      case (mode_n)
        2'd0:    data_n = x_n[11:0];
        2'd1:    data_n = (x_n[3] ^ y_n[3]) ? 12'hFFF : 12'h000;
        2'd2:    data_n = const_n;
        default: data_n = x_n[11:0] + y_n[11:0] + frame_n[11:0];
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state   <= S_IDLE;
      cnt     <= '0;
      frame_q <= '0;
      mode_q  <= '0;
      const_q <= '0;
      stop_q  <= 1'b0;
      oX_Cont <= '0;
      oY_Cont <= '0;
      oDATA   <= '0;
      oFVAL   <= 1'b0;
      oLVAL   <= 1'b0;
      oBUSY   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      frame_q <= frame_n;
      mode_q  <= mode_n;
      const_q <= const_n;
      stop_q  <= stop_n;
      oX_Cont <= x_n;
      oY_Cont <= y_n;
      oDATA   <= data_n;
      oFVAL   <= (state_n == S_PRE) || (state_n == S_LINE) ||
                 (state_n == S_HBL) || (state_n == S_POST);
      oLVAL   <= (state_n == S_LINE);
      oBUSY   <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_d5m_stream_gen.sv
// Directed bench for d5m_stream_gen with a small frame geometry
// (8x4 active, 3 H blank, 2/2 P blank, 5 V blank => 45 FVAL cycles per frame).
module tb_d5m_stream_gen;

  logic        iCLK = 1'b0;
  logic        iRST_N, iSTART, iEND;
  logic [1:0]  iMODE;
  logic [11:0] iCONST;
  logic [11:0] oDATA;
  logic        oFVAL, oLVAL, oBUSY;
  logic [15:0] oX_Cont, oY_Cont, oFrame_Cont;

  int n_chk  = 0;
  int n_fail = 0;

  d5m_stream_gen #(
    .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(3),
    .P1_BLANK(2), .P2_BLANK(2), .V_BLANK(5)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iSTART(iSTART), .iEND(iEND),
    .iMODE(iMODE), .iCONST(iCONST), .oDATA(oDATA), .oFVAL(oFVAL),
    .oLVAL(oLVAL), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont),
    .oFrame_Cont(oFrame_Cont), .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int          cyc;
    logic        fval;
    logic        lval;
    logic [11:0] data;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] f;
    logic        busy;
  } vec_t;

  vec_t tbl[14];

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    iRST_N = 1'b0;
    iSTART = 1'b0;
    iEND   = 1'b0;
    iMODE  = 2'd0;
    iCONST = 12'h000;
    tick();
    tick();
    iRST_N = 1'b1;
  endtask

  int fcnt, lrise, lhi, dbad, vlow, bad0, bad1, n1, late;
  logic prev_l;

  initial begin
    // cyc, fval, lval, data, x, y, frame, busy
    tbl[0]  = '{1,  1'b1, 1'b0, 12'd0, 16'd0, 16'd0, 16'd0, 1'b1};
    tbl[1]  = '{2,  1'b1, 1'b0, 12'd0, 16'd0, 16'd0, 16'd0, 1'b1};
    tbl[2]  = '{3,  1'b1, 1'b1, 12'd0, 16'd0, 16'd0, 16'd0, 1'b1};
    tbl[3]  = '{10, 1'b1, 1'b1, 12'd7, 16'd7, 16'd0, 16'd0, 1'b1};
    tbl[4]  = '{11, 1'b1, 1'b0, 12'd0, 16'd7, 16'd0, 16'd0, 1'b1};
    tbl[5]  = '{13, 1'b1, 1'b0, 12'd0, 16'd7, 16'd0, 16'd0, 1'b1};
    tbl[6]  = '{14, 1'b1, 1'b1, 12'd0, 16'd0, 16'd1, 16'd0, 1'b1};
    tbl[7]  = '{28, 1'b1, 1'b1, 12'd3, 16'd3, 16'd2, 16'd0, 1'b1};
    tbl[8]  = '{43, 1'b1, 1'b1, 12'd7, 16'd7, 16'd3, 16'd0, 1'b1};
    tbl[9]  = '{44, 1'b1, 1'b0, 12'd0, 16'd7, 16'd3, 16'd0, 1'b1};
    tbl[10] = '{45, 1'b1, 1'b0, 12'd0, 16'd7, 16'd3, 16'd0, 1'b1};
    tbl[11] = '{46, 1'b0, 1'b0, 12'd0, 16'd7, 16'd3, 16'd1, 1'b1};
    tbl[12] = '{50, 1'b0, 1'b0, 12'd0, 16'd7, 16'd3, 16'd1, 1'b1};
    tbl[13] = '{51, 1'b1, 1'b0, 12'd0, 16'd7, 16'd0, 16'd1, 1'b1};

    // Reset state
    do_reset();
    chk("rst_fval", 32'(oFVAL), 0);
    chk("rst_lval", 32'(oLVAL), 0);
    chk("rst_data", 32'(oDATA), 0);
    chk("rst_x", 32'(oX_Cont), 0);
    chk("rst_y", 32'(oY_Cont), 0);
    chk("rst_frame", 32'(oFrame_Cont), 0);
    chk("rst_busy", 32'(oBUSY), 0);

    // Frame timing, mode 0
    iMODE = 2'd0;
    iSTART = 1'b1;
    fcnt = 0; lrise = 0; lhi = 0; dbad = 0; prev_l = 1'b0;
    for (int c = 1; c <= 51; c++) begin
      tick();
      iSTART = 1'b0;
      if (c <= 50) begin
        fcnt += int'(oFVAL);
        if (oLVAL && !prev_l) lrise++;
        prev_l = oLVAL;
        lhi += int'(oLVAL);
        if (oLVAL ? (oDATA != oX_Cont[11:0]) : (oDATA != 12'd0)) dbad++;
      end
      for (int j = 0; j < 14; j++) begin
        if (tbl[j].cyc == c) begin
          chk($sformatf("t1_fval_c%0d", c), 32'(oFVAL), 32'(tbl[j].fval));
          chk($sformatf("t1_lval_c%0d", c), 32'(oLVAL), 32'(tbl[j].lval));
          chk($sformatf("t1_data_c%0d", c), 32'(oDATA), 32'(tbl[j].data));
          chk($sformatf("t1_x_c%0d", c), 32'(oX_Cont), 32'(tbl[j].x));
          chk($sformatf("t1_y_c%0d", c), 32'(oY_Cont), 32'(tbl[j].y));
          chk($sformatf("t1_frame_c%0d", c), 32'(oFrame_Cont), 32'(tbl[j].f));
          chk($sformatf("t1_busy_c%0d", c), 32'(oBUSY), 32'(tbl[j].busy));
        end
      end
    end
    chk("t1_fval_len", 32'(fcnt), 45);
    chk("t1_lval_pulses", 32'(lrise), 4);
    chk("t1_lval_cycles", 32'(lhi), 32);
    chk("t1_data_eq_x", 32'(dbad), 0);

    // Continuous run, mode 3
    do_reset();
    iMODE = 2'd3;
    iSTART = 1'b1;
    vlow = 0;
    for (int c = 1; c <= 82; c++) begin
      tick();
      if (c >= 45 && c <= 52 && !oFVAL) vlow++;
      if (c == 20) chk("t2_data_f0_l1_x6", 32'(oDATA), 7);
      if (c == 75) begin
        chk("t2_y_line2", 32'(oY_Cont), 2);
        chk("t2_frame1", 32'(oFrame_Cont), 1);
      end
      if (c >= 75) chk($sformatf("t2_data_c%0d", c), 32'(oDATA), 32'(c - 72));
    end
    chk("t2_vblank_len", 32'(vlow), 5);
    iSTART = 1'b0;

    // Checker, then constant latched only at the next frame
    do_reset();
    iMODE = 2'd1;
    iSTART = 1'b1;
    bad0 = 0; bad1 = 0; n1 = 0;
    for (int c = 1; c <= 100; c++) begin
      tick();
      iSTART = 1'b0;
      if (c == 20) begin
        iMODE = 2'd2;
        iCONST = 12'hABC;
      end
      if (c <= 45 && oLVAL && oDATA != 12'h000) bad0++;
      if (c >= 51 && c <= 95 && oLVAL) begin
        n1++;
        if (oDATA != 12'hABC) bad1++;
      end
    end
    chk("t3_checker_zero", 32'(bad0), 0);
    chk("t3_const_lines", 32'(n1), 32);
    chk("t3_const_abc", 32'(bad1), 0);

    // Stop request mid-frame
    do_reset();
    iMODE = 2'd0;
    iSTART = 1'b1;
    fcnt = 0; late = 0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      iSTART = 1'b0;
      iEND = (c == 15);
      fcnt += int'(oFVAL);
      if (c == 50) chk("t4_busy_vbl_end", 32'(oBUSY), 1);
      if (c == 51) chk("t4_busy_idle", 32'(oBUSY), 0);
      if (c >= 51 && (oFVAL || oBUSY)) late++;
    end
    chk("t4_fval_len", 32'(fcnt), 45);
    chk("t4_no_restart", 32'(late), 0);
    iSTART = 1'b1;
    iEND = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    chk("t4_start_end_busy", 32'(oBUSY), 0);
    chk("t4_start_end_fval", 32'(oFVAL), 0);
    iSTART = 1'b0;
    iEND = 1'b0;

    // Reset in the middle of line 2 of frame 1
    do_reset();
    iMODE = 2'd0;
    iSTART = 1'b1;
    for (int c = 1; c <= 77; c++) begin
      tick();
      iSTART = 1'b0;
    end
    chk("t5_pre_lval", 32'(oLVAL), 1);
    chk("t5_pre_frame", 32'(oFrame_Cont), 1);
    iRST_N = 1'b0;
    tick();
    chk("t5_fval", 32'(oFVAL), 0);
    chk("t5_lval", 32'(oLVAL), 0);
    chk("t5_data", 32'(oDATA), 0);
    chk("t5_frame", 32'(oFrame_Cont), 0);
    chk("t5_busy", 32'(oBUSY), 0);
    iRST_N = 1'b1;
    late = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (oFVAL || oLVAL || oBUSY || oDATA != 12'd0) late++;
    end
    chk("t5_stays_idle", 32'(late), 0);

    // Frame counter wrap
    do_reset();
    force dut.frame_q = 16'hFFFF;
    tick();
    release dut.frame_q;
    tick();
    chk("t6_preload", 32'(oFrame_Cont), 32'h0000FFFF);
    iSTART = 1'b1;
    for (int c = 1; c <= 46; c++) begin
      tick();
      iSTART = 1'b0;
      if (c == 45) chk("t6_frame_c45", 32'(oFrame_Cont), 32'h0000FFFF);
      if (c == 46) chk("t6_frame_wrap", 32'(oFrame_Cont), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
